negator_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one registered negator datapath among NUM_REQ requesters. It sits in front of the datapath, taking requests over valid/ready handshakes and issuing at most one operand per cycle. A tag pipeline tracks which requester owns each in-flight result, so results return to the correct requester after the datapath's fixed latency. It also flags any mismatch between issued and returned valids.

---
 rtl/negator_rr_arbiter_if.sv | 40 ++++
 rtl/negator_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_negator_rr_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/negator_rr_arbiter_if.sv
// Handshake and datapath bundle shared by the round-robin negator arbiter and its environment.
// The slave modport is the arbiter's view; master is the requesters plus the datapath.
interface negator_rr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          dp_input_valid;
  logic [DATA_WIDTH-1:0]         dp_input_data;
  logic                          dp_output_valid;
  logic [DATA_WIDTH-1:0]         dp_output_data;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [DATA_WIDTH-1:0]         resp_data;

  modport slave (
    input  req_valid,
    input  req_data,
    input  dp_output_valid,
    input  dp_output_data,
    output req_ready,
    output dp_input_valid,
    output dp_input_data,
    output resp_valid,
    output resp_data
  );

  modport master (
    output req_valid,
    output req_data,
    output dp_output_valid,
    output dp_output_data,
    input  req_ready,
    input  dp_input_valid,
    input  dp_input_data,
    input  resp_valid,
    input  resp_data
  );
endinterface

// File: rtl/negator_rr_arbiter.sv
// Round-robin arbiter feeding a shared fixed-latency negator datapath; a tag pipeline
// routes each result back to its requester and flags issue/return valid mismatches.
module negator_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DP_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  negator_rr_arbiter_if.slave bus,
  output logic                busy,
  output logic                seq_error
);
  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [PtrW-1:0]       cand;
  logic [PtrW-1:0]       winner;
  logic                  found;
  logic                  grant;
  logic                  accept;
  logic [NUM_REQ-1:0]    ready;
  logic [NUM_REQ-1:0]    resp;

  logic [DP_LATENCY-1:0] tag_vld_q;
  logic [PtrW-1:0]       tag_idx_q [DP_LATENCY];
  logic                  valid_last;
  logic [PtrW-1:0]       idx_last;

  logic                  seq_error_q, seq_error_d;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PtrW'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign grant = found & enable & ~reset;

  always_comb begin
    ready = '0;
    if (grant) begin
      ready[winner] = 1'b1;
    end
  end

  assign bus.req_ready = ready;
  assign accept        = |(bus.req_valid & ready);

  assign bus.dp_input_valid = accept;
  assign bus.dp_input_data  = accept ? bus.req_data[32'(winner) * DATA_WIDTH +: DATA_WIDTH]
                                     : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (32'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Tag pipeline mirrors the datapath latency so each result knows its owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_vld_q <= '0;
      for (int k = 0; k < DP_LATENCY; k++) begin
        tag_idx_q[k] <= '0;
      end
    end else begin
      tag_vld_q[0] <= accept;
      tag_idx_q[0] <= winner;
      for (int k = 1; k < DP_LATENCY; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_idx_q[k] <= tag_idx_q[k-1];
      end
    end
  end

  assign valid_last = tag_vld_q[DP_LATENCY-1];
  assign idx_last   = tag_idx_q[DP_LATENCY-1];

  always_comb begin
    resp = '0;
    if (!reset && bus.dp_output_valid && valid_last) begin
      resp[idx_last] = 1'b1;
    end
  end

  assign bus.resp_valid = resp;
  assign bus.resp_data  = bus.dp_output_data;

  assign seq_error_d = seq_error_q | (bus.dp_output_valid != valid_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      seq_error_q <= 1'b0;
    end else begin
      seq_error_q <= seq_error_d;
    end
  end

  assign busy      = |tag_vld_q;
  assign seq_error = seq_error_q;

  ready_onehot_a: assert property (@(posedge clock) $onehot0(ready));
  resp_onehot_a:  assert property (@(posedge clock) $onehot0(resp));
  grant_valid_a:  assert property (@(posedge clock) disable iff (reset)
                                   grant |-> bus.req_valid[winner]);
endmodule

// File: tb/tb_negator_rr_arbiter.sv
// Randomised and directed bench for negator_rr_arbiter against a queue-based reference model,
// with a behavioural negator datapath closing the loop.
module tb_negator_rr_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 64;
  localparam int unsigned L = 3;

  logic clock = 1'b0;
  logic reset;
  logic enable;
  logic inject;
  logic busy;
  logic seq_error;

  logic [N-1:0]   rv;
  logic [N*W-1:0] rd;

  negator_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();

  negator_rr_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(W),
    .DP_LATENCY(L)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus),
    .busy     (busy),
    .seq_error(seq_error)
  );

  always #5 clock = ~clock;

  assign bus.req_valid = rv;
  assign bus.req_data  = rd;

  // Behavioural negator datapath, reset together with the arbiter.
  logic [L-1:0] dp_vld;
  logic [W-1:0] dp_dat [L];

  always @(posedge clock) begin
    if (reset) begin
      dp_vld <= '0;
      for (int k = 0; k < L; k++) dp_dat[k] <= '0;
    end else begin
      dp_vld[0] <= bus.dp_input_valid;
      dp_dat[0] <= W'(0) - bus.dp_input_data;
      for (int k = 1; k < L; k++) begin
        dp_vld[k] <= dp_vld[k-1];
        dp_dat[k] <= dp_dat[k-1];
      end
    end
  end

  assign bus.dp_output_valid = dp_vld[L-1] | inject;
  assign bus.dp_output_data  = dp_dat[L-1];

  typedef struct {
    int           due;
    int           idx;
    logic [W-1:0] data;
  } resp_t;

  resp_t pend[$];
  int    m_ptr;
  bit    m_err;
  int    cyc;
  int    n_checks;
  int    n_pass;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One clock: predict and compare at the negedge, advance the model at the posedge.
  task automatic step();
    int           w;
    bit           fnd;
    bit           acc;
    bit           due;
    bit           obs_dpv;
    resp_t        e;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_resp;
    @(negedge clock);
    fnd = 1'b0;
    w   = 0;
    for (int k = 0; k < int'(N); k++) begin
      if (!fnd && rv[(m_ptr + k) % N]) begin
        fnd = 1'b1;
        w   = (m_ptr + k) % N;
      end
    end
    acc       = fnd && enable && !reset;
    exp_ready = '0;
    if (acc) exp_ready[w] = 1'b1;
    due = (pend.size() > 0) && (pend[0].due == cyc);
    if (due) e = pend[0];
    exp_resp = '0;
    if (due && !reset) exp_resp[e.idx] = 1'b1;
    obs_dpv = bus.dp_output_valid;

    check_eq("req_ready", W'(bus.req_ready), W'(exp_ready));
    check_eq("dp_input_valid", W'(bus.dp_input_valid), W'(acc));
    check_eq("dp_input_data", bus.dp_input_data, acc ? rd[w*W +: W] : W'(0));
    check_eq("resp_valid", W'(bus.resp_valid), W'(exp_resp));
    if (due && !reset) check_eq("resp_data", bus.resp_data, e.data);
    if (!reset) begin
      check_eq("busy", W'(busy), W'(pend.size() != 0));
      check_eq("seq_error", W'(seq_error), W'(m_err));
    end

    @(posedge clock);
    if (reset) begin
      pend.delete();
      m_ptr = 0;
      m_err = 1'b0;
    end else begin
      if (obs_dpv != due) m_err = 1'b1;
      if (due) void'(pend.pop_front());
      if (acc) begin
        pend.push_back('{cyc + int'(L), w, W'(0) - rd[w*W +: W]});
        m_ptr = (w + 1) % N;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    rv = '0;
    repeat (L + 1) step();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    m_ptr    = 0;
    m_err    = 1'b0;
    rv       = '0;
    rd       = '0;
    enable   = 1'b1;
    inject   = 1'b0;
    reset    = 1'b1;
    repeat (2) step();
    reset = 1'b0;

    // Single requester 2 with operand 5.
    rv = 4'b0100;
    rd[2*W +: W] = 64'd5;
    step();
    drain();

    // Full burst from ptr 0.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < int'(N); i++) rd[i*W +: W] = W'(i + 1);
    rv = 4'b1111;
    repeat (8) step();
    drain();

    // Wrap-around and idle skipping.
    rv = 4'b0100;
    step();
    rv = 4'b1001;
    repeat (2) step();
    rv = 4'b0001;
    step();
    drain();

    // Enable dropped mid-burst.
    rv = 4'b1111;
    repeat (3) step();
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    repeat (4) step();
    drain();

    // Orphan datapath valid sets the sticky error.
    inject = 1'b1;
    step();
    inject = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Reset with two operations in flight.
    rv = 4'b1111;
    repeat (2) step();
    rv = '0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (L + 2) step();
    rv = 4'b1111;
    step();
    drain();

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      rv = N'($urandom);
      for (int i = 0; i < int'(N); i++) rd[i*W +: W] = {$urandom, $urandom};
      enable = ($urandom_range(0, 7) != 0);
      reset  = ($urandom_range(0, 49) == 0);
      step();
    end
    reset  = 1'b0;
    enable = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
